// File: rtl/tri_setup_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tri_setup_pkg
//  Description : Shared types and constants for the triangle-setup sequencer:
//                FSM state encoding, cull-mode codes, vertex field layout.
//  Revision    : 1.0  initial release
// ============================================================================
package tri_setup_pkg;

  // Default coordinate width and packed triangle width
  localparam int COORD_W_DFLT = 16;
  localparam int TRI_W        = 6 * COORD_W_DFLT;

  // Coordinate slot index inside the packed triangle {v2y,v2x,v1y,v1x,v0y,v0x}
  localparam int V0X_IDX = 0;
  localparam int V0Y_IDX = 1;
  localparam int V1X_IDX = 2;
  localparam int V1Y_IDX = 3;
  localparam int V2X_IDX = 4;
  localparam int V2Y_IDX = 5;

  // Cull-mode codes; 2'b11 behaves like CULL_NONE
  localparam logic [1:0] CULL_NONE = 2'b00;
  localparam logic [1:0] CULL_CW   = 2'b01;
  localparam logic [1:0] CULL_CCW  = 2'b10;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  // Packs six default-width coordinates into the triangle bus layout
  function automatic logic [TRI_W-1:0] tri_pack(
    input logic [COORD_W_DFLT-1:0] v0x, input logic [COORD_W_DFLT-1:0] v0y,
    input logic [COORD_W_DFLT-1:0] v1x, input logic [COORD_W_DFLT-1:0] v1y,
    input logic [COORD_W_DFLT-1:0] v2x, input logic [COORD_W_DFLT-1:0] v2y);
    logic [TRI_W-1:0] t;
    t = '0;
    t[V0X_IDX*COORD_W_DFLT +: COORD_W_DFLT] = v0x;
    t[V0Y_IDX*COORD_W_DFLT +: COORD_W_DFLT] = v0y;
    t[V1X_IDX*COORD_W_DFLT +: COORD_W_DFLT] = v1x;
    t[V1Y_IDX*COORD_W_DFLT +: COORD_W_DFLT] = v1y;
    t[V2X_IDX*COORD_W_DFLT +: COORD_W_DFLT] = v2x;
    t[V2Y_IDX*COORD_W_DFLT +: COORD_W_DFLT] = v2y;
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tri_setup_if.sv
`default_nettype none
// ============================================================================
//  Module      : tri_setup_if
//  Description : Bundle of the triangle input handshake, the area-unit
//                control/result signals, the setup output handshake and the
//                status outputs. slave = sequencer side, master = environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface tri_setup_if #(
  parameter int COORD_W = 16
);
  // Triangle input handshake
  logic                   in_valid;
  logic                   in_ready;
  logic [6*COORD_W-1:0]   in_tri;
  logic [1:0]             cull_mode;
  // Area unit
  logic                   ar_start;
  logic                   ar_rst;
  logic [6*COORD_W-1:0]   ar_tri;
  logic                   ar_done;
  logic [COORD_W-1:0]     ar_area;
  // Setup result handshake
  logic                   out_valid;
  logic                   out_ready;
  logic [6*COORD_W-1:0]   out_tri;
  logic [COORD_W-1:0]     out_area;
  logic                   out_ccw;
  // Status
  logic [15:0]            culled_cnt;
  logic                   err_timeout;

  modport slave (
    input  in_valid, in_tri, cull_mode, ar_done, ar_area, out_ready,
    output in_ready, ar_start, ar_rst, ar_tri, out_valid, out_tri, out_area,
           out_ccw, culled_cnt, err_timeout
  );

  modport master (
    output in_valid, in_tri, cull_mode, ar_done, ar_area, out_ready,
    input  in_ready, ar_start, ar_rst, ar_tri, out_valid, out_tri, out_area,
           out_ccw, culled_cnt, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/tri_cull_check.sv
`default_nettype none
// ============================================================================
//  Module      : tri_cull_check
//  Description : Combinational cull decision from a signed area and cull mode.
//                Degenerate (|area| < AREA_MIN) is always culled; otherwise
//                the mode selects which winding is rejected.
//  Revision    : 1.0  initial release
// ============================================================================
module tri_cull_check
  import tri_setup_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int AREA_MIN = 1
) (
  input  wire logic [COORD_W-1:0] i_area,
  input  wire logic [1:0]         i_mode,
  output logic                    o_cull,
  output logic                    o_ccw
);
  localparam logic [COORD_W:0] c_AMIN = AREA_MIN[COORD_W:0];

  logic             w_neg;
  logic             w_zero;
  logic             w_pos;
  logic [COORD_W:0] w_ext;
  logic [COORD_W:0] w_mag;
  logic             w_degen;

  // Magnitude is one bit wider so the most negative area is not seen as small
  assign w_neg   = i_area[COORD_W-1];
  assign w_zero  = (i_area == '0);
  assign w_pos   = ~w_neg & ~w_zero;
  assign w_ext   = {i_area[COORD_W-1], i_area};
  assign w_mag   = w_neg ? (~w_ext + 1'b1) : w_ext;
  assign w_degen = (w_mag < c_AMIN);

  assign o_ccw  = w_pos;
  assign o_cull = w_degen
                | ((i_mode == CULL_CW)  & w_neg)
                | ((i_mode == CULL_CCW) & w_pos);

endmodule
`default_nettype wire

// File: rtl/tri_setup_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tri_setup_ctrl
//  Description : Triangle-setup sequencer. Accepts one triangle, starts the
//                shared area unit, waits for its done pulse with a timeout,
//                culls degenerate/back-facing triangles and forwards the rest.
//                A timeout soft-resets the area unit and sets a sticky error.
//  Revision    : 1.0  initial release
// ============================================================================
module tri_setup_ctrl
  import tri_setup_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int TIMEOUT  = 15,
  parameter int AREA_MIN = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  tri_setup_if.slave  bus
);
  localparam int          c_TRI_W   = 6 * COORD_W;
  localparam logic [7:0]  c_TIMEOUT = TIMEOUT[7:0];

  state_t               r_state;
  state_t               w_next;
  logic [c_TRI_W-1:0]   r_tri;
  logic [1:0]           r_mode;
  logic [COORD_W-1:0]   r_area;
  logic                 r_ccw;
  logic [7:0]           r_timer;
  logic [15:0]          r_culled_cnt;
  logic                 r_err;

  logic                 w_cull;
  logic                 w_ccw;
  logic                 w_done;
  logic                 w_expired;
  logic                 w_accept;
  logic                 w_start;
  logic                 w_recover;
  logic                 w_out_valid;

  tri_cull_check #(
    .COORD_W  (COORD_W),
    .AREA_MIN (AREA_MIN)
  ) u_cull (
    .i_area (bus.ar_area),
    .i_mode (r_mode),
    .o_cull (w_cull),
    .o_ccw  (w_ccw)
  );

  // A done pulse in the same cycle as the last timer value takes priority
  assign w_done    = (r_state == ST_WAIT) & bus.ar_done;
  assign w_expired = (r_state == ST_WAIT) & ~bus.ar_done & (r_timer == c_TIMEOUT);
  assign w_accept  = (r_state == ST_IDLE) & bus.in_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded strobes
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_recover   = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) w_next = ST_START;
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done)         w_next = w_cull ? ST_IDLE : ST_OUT;
        else if (w_expired) w_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        w_recover = 1'b1;
        w_next    = ST_IDLE;
      end
      ST_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: triangle/mode capture, timer, result latch, counters, error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tri        <= '0;
      r_mode       <= CULL_NONE;
      r_area       <= '0;
      r_ccw        <= 1'b0;
      r_timer      <= '0;
      r_culled_cnt <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tri  <= bus.in_tri;
        r_mode <= bus.cull_mode;
      end
      if (r_state == ST_START) begin
        r_timer <= '0;
      end
      if (r_state == ST_WAIT) begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_done) begin
        r_area <= bus.ar_area;
        r_ccw  <= w_ccw;
        if (w_cull && (r_culled_cnt != 16'hFFFF)) begin
          r_culled_cnt <= r_culled_cnt + 16'd1;
        end
      end
      if (w_expired) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE) & ~rst;
  assign bus.ar_start    = w_start;
  assign bus.ar_rst      = rst | w_recover;
  assign bus.ar_tri      = r_tri;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_tri     = r_tri;
  assign bus.out_area    = r_area;
  assign bus.out_ccw     = r_ccw;
  assign bus.culled_cnt  = r_culled_cnt;
  assign bus.err_timeout = r_err;

endmodule
`default_nettype wire
